// File: rtl/psum_pkg.sv
// Shared constants and state encoding for the systolic-array output collector.
package psum_pkg;
  localparam int COL_NUM    = 32;
  localparam int PSUM_WIDTH = 32;
  localparam int OUT_WIDTH  = 8;
  localparam int RQ_WIDTH   = 38;
  localparam int BANK_NUM   = 4;
  localparam int BANK_WIDTH = COL_NUM * OUT_WIDTH / BANK_NUM;
  localparam int ROW_WIDTH  = 12;
  localparam int BEAT_WIDTH = 14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;
endpackage

// File: rtl/psum_requant.sv
// One-column requantizer: rounding arithmetic shift, optional ReLU, signed saturation.
module psum_requant #(
  parameter int PSUM_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int RQ_WIDTH   = 38
) (
  input  logic [PSUM_WIDTH-1:0] psum,
  input  logic [4:0]            shamt,
  input  logic                  relu_en,
  output logic [OUT_WIDTH-1:0]  q
);
  localparam logic signed [RQ_WIDTH-1:0] QMAX = RQ_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RQ_WIDTH-1:0] QMIN = ~QMAX;

  logic signed [RQ_WIDTH-1:0] ext;
  logic signed [RQ_WIDTH-1:0] rnd;
  logic signed [RQ_WIDTH-1:0] shifted;
  logic signed [RQ_WIDTH-1:0] clamped;

  always_comb begin
    ext     = RQ_WIDTH'(signed'(psum));
    rnd     = (shamt == '0) ? '0 : (RQ_WIDTH'(1) << (shamt - 5'd1));
    shifted = (ext + rnd) >>> shamt;
    clamped = shifted;
    if (relu_en && (shifted < 0)) clamped = '0;
    if (clamped > QMAX)      clamped = QMAX;
    else if (clamped < QMIN) clamped = QMIN;
    q = clamped[OUT_WIDTH-1:0];
  end
endmodule

// File: rtl/psum_collect.sv
// De-skews the array's bottom-edge partial sums into rows, requantizes them and
// writes each row across four 64-bit SRAM banks with a ping-pong base.
module psum_collect #(
  parameter int COL_NUM    = psum_pkg::COL_NUM,
  parameter int PSUM_WIDTH = psum_pkg::PSUM_WIDTH,
  parameter int OUT_WIDTH  = psum_pkg::OUT_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                pingpang,
  input  logic [12:0]                         rows,
  input  logic [4:0]                          shamt,
  input  logic                                relu_en,
  input  logic [COL_NUM*PSUM_WIDTH-1:0]       psum_in_skewed,
  input  logic                                psum_in_valid,
  output logic                                bwe0,
  output logic                                bwe1,
  output logic                                bwe2,
  output logic                                bwe3,
  output logic [14:0]                         bwaddr0,
  output logic [14:0]                         bwaddr1,
  output logic [14:0]                         bwaddr2,
  output logic [14:0]                         bwaddr3,
  output logic [psum_pkg::BANK_WIDTH-1:0]     bwdata0,
  output logic [psum_pkg::BANK_WIDTH-1:0]     bwdata1,
  output logic [psum_pkg::BANK_WIDTH-1:0]     bwdata2,
  output logic [psum_pkg::BANK_WIDTH-1:0]     bwdata3,
  output logic                                busy,
  output logic                                done,
  output logic                                overrun
);
  import psum_pkg::*;

  localparam int ROW_BITS = COL_NUM * OUT_WIDTH;
  localparam logic [BEAT_WIDTH-1:0] FILL_BEATS = BEAT_WIDTH'(COL_NUM - 1);

  state_t                  state;
  logic [12:0]             rows_l;
  logic [4:0]              shamt_l;
  logic                    relu_l;
  logic                    pp_l;
  logic                    job_seen;
  logic [BEAT_WIDTH-1:0]   beat;
  logic [BEAT_WIDTH-1:0]   last_beat;
  logic [ROW_WIDTH-1:0]    row;
  logic [ROW_WIDTH-1:0]    s1_row;
  logic                    s1_valid;
  logic [ROW_BITS-1:0]     s1_data;
  logic                    bwe_r;
  logic [14:0]             bwaddr_r;
  logic [ROW_BITS-1:0]     bwdata_r;
  logic [ROW_BITS-1:0]     rq_row;
  logic [PSUM_WIDTH-1:0]   aligned [COL_NUM];
  logic [OUT_WIDTH-1:0]    rq_q [COL_NUM];
  logic                    shift_en;

  assign last_beat = BEAT_WIDTH'(rows_l) + BEAT_WIDTH'(COL_NUM - 2);
  assign shift_en  = (state == ST_COLLECT) && psum_in_valid && !start;

  // Column j is delayed COL_NUM-1-j accepted beats so all columns line up on one row.
  for (genvar j = 0; j < COL_NUM; j++) begin : g_col
    if (j == COL_NUM - 1) begin : g_pass
      assign aligned[j] = psum_in_skewed[j*PSUM_WIDTH +: PSUM_WIDTH];
    end else begin : g_dly
      localparam int DEPTH = COL_NUM - 1 - j;
      logic [PSUM_WIDTH-1:0] dl [DEPTH];
      always_ff @(posedge clk) begin
        if (shift_en) begin
          dl[0] <= psum_in_skewed[j*PSUM_WIDTH +: PSUM_WIDTH];
          for (int unsigned k = 1; k < DEPTH; k++) dl[k] <= dl[k-1];
        end
      end
      assign aligned[j] = dl[DEPTH-1];
    end

    psum_requant #(
      .PSUM_WIDTH (PSUM_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .RQ_WIDTH   (RQ_WIDTH)
    ) u_rq (
      .psum    (aligned[j]),
      .shamt   (shamt_l),
      .relu_en (relu_l),
      .q       (rq_q[j])
    );
  end

  always_comb begin
    rq_row = '0;
    for (int unsigned j = 0; j < COL_NUM; j++) rq_row[j*OUT_WIDTH +: OUT_WIDTH] = rq_q[j];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rows_l   <= '0;
      shamt_l  <= '0;
      relu_l   <= 1'b0;
      pp_l     <= 1'b0;
      job_seen <= 1'b0;
      beat     <= '0;
      row      <= '0;
      s1_valid <= 1'b0;
      s1_row   <= '0;
      s1_data  <= '0;
      bwe_r    <= 1'b0;
      bwaddr_r <= '0;
      bwdata_r <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done     <= 1'b0;
      s1_valid <= 1'b0;
      bwe_r    <= s1_valid;
      if (s1_valid) begin
        bwaddr_r <= {pp_l, s1_row, 2'b00};
        bwdata_r <= s1_data;
      end

      if (start) begin
        // Abort drops both pipeline stages; de-skew contents are flushed by fill beats.
        state    <= (rows == '0) ? ST_DRAIN : ST_COLLECT;
        rows_l   <= rows;
        shamt_l  <= shamt;
        relu_l   <= relu_en;
        pp_l     <= pingpang;
        job_seen <= 1'b1;
        beat     <= '0;
        row      <= '0;
        bwe_r    <= 1'b0;
        busy     <= 1'b1;
        overrun  <= 1'b0;
      end else begin
        case (state)
          ST_COLLECT: begin
            if (psum_in_valid) begin
              beat <= beat + 1'b1;
              if (beat >= FILL_BEATS) begin
                s1_valid <= 1'b1;
                s1_row   <= row;
                s1_data  <= rq_row;
                row      <= row + 1'b1;
              end
              if (beat == last_beat) begin
                state <= ST_DRAIN;
                beat  <= '0;
                row   <= '0;
              end
            end
          end
          ST_DRAIN: begin
            if (psum_in_valid) overrun <= 1'b1;
            if (!s1_valid) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: begin
            if (psum_in_valid && job_seen) overrun <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bwe0    = bwe_r;
  assign bwe1    = bwe_r;
  assign bwe2    = bwe_r;
  assign bwe3    = bwe_r;
  assign bwaddr0 = bwaddr_r;
  assign bwaddr1 = bwaddr_r;
  assign bwaddr2 = bwaddr_r;
  assign bwaddr3 = bwaddr_r;
  assign bwdata0 = bwdata_r[0*BANK_WIDTH +: BANK_WIDTH];
  assign bwdata1 = bwdata_r[1*BANK_WIDTH +: BANK_WIDTH];
  assign bwdata2 = bwdata_r[2*BANK_WIDTH +: BANK_WIDTH];
  assign bwdata3 = bwdata_r[3*BANK_WIDTH +: BANK_WIDTH];
endmodule

// File: tb/tb_psum_collect.sv
// Directed/random bench for psum_collect: rows are generated as a matrix, skewed
// into the input stream, and the captured SRAM writes are compared to a row model.
module tb_psum_collect;
  localparam int C  = 32;
  localparam int PW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            pingpang = 1'b0;
  logic [12:0]     rows = '0;
  logic [4:0]      shamt = '0;
  logic            relu_en = 1'b0;
  logic [C*PW-1:0] psum_in_skewed = '0;
  logic            psum_in_valid = 1'b0;
  logic            bwe0, bwe1, bwe2, bwe3;
  logic [14:0]     bwaddr0, bwaddr1, bwaddr2, bwaddr3;
  logic [63:0]     bwdata0, bwdata1, bwdata2, bwdata3;
  logic            busy, done, overrun;

  psum_collect #(.COL_NUM(C), .PSUM_WIDTH(PW), .OUT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pingpang(pingpang), .rows(rows),
    .shamt(shamt), .relu_en(relu_en), .psum_in_skewed(psum_in_skewed),
    .psum_in_valid(psum_in_valid),
    .bwe0(bwe0), .bwe1(bwe1), .bwe2(bwe2), .bwe3(bwe3),
    .bwaddr0(bwaddr0), .bwaddr1(bwaddr1), .bwaddr2(bwaddr2), .bwaddr3(bwaddr3),
    .bwdata0(bwdata0), .bwdata1(bwdata1), .bwdata2(bwdata2), .bwdata3(bwdata3),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int unsigned  cyc;
    logic [3:0]   we;
    logic [59:0]  addr;
    logic [255:0] data;
  } wr_t;

  wr_t         wq[$];
  int          done_cnt = 0;
  int unsigned done_cyc = 0;
  logic        done_busy = 1'b0;

  always @(negedge clk) begin
    wr_t w;
    if (bwe0 | bwe1 | bwe2 | bwe3) begin
      w.cyc  = cyc;
      w.we   = {bwe3, bwe2, bwe1, bwe0};
      w.addr = {bwaddr3, bwaddr2, bwaddr1, bwaddr0};
      w.data = {bwdata3, bwdata2, bwdata1, bwdata0};
      wq.push_back(w);
    end
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
    end
  end

  int          mat [4096][C];
  int unsigned beat_cyc [4200];
  int unsigned start_cyc;
  int          cur_rows;
  int          n_assert = 0;
  int          n_fail = 0;
  int          sh_r;
  bit          rl_r;
  int          cp  [5] = '{-1, 5, 1000, -1000, -1000};
  int          csh [5] = '{1, 1, 2, 0, 0};
  bit          crl [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0]  cq  [5] = '{8'h00, 8'h03, 8'h7f, 8'h80, 8'h00};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requant rule from the datasheet, evaluated in 64-bit arithmetic.
  function automatic int rq_model(input int p, input int sh, input bit relu);
    longint t;
    t = longint'(p);
    if (sh > 0) t = t + (longint'(1) << (sh - 1));
    t = t >>> sh;
    if (relu && t < 0) t = 0;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return int'(t);
  endfunction

  task automatic fill_mat(input int n, input bit rnd);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < C; j++) begin
        if (!rnd) mat[i][j] = i;
        else case ($urandom_range(0, 3))
          0: mat[i][j] = int'($urandom);
          1: mat[i][j] = int'($urandom_range(0, 2000)) - 1000;
          2: mat[i][j] = ($urandom_range(0, 1) == 1) ? 32'h7fffffff : 32'h80000000;
          default: mat[i][j] = int'($urandom) >>> $urandom_range(0, 30);
        endcase
      end
  endtask

  task automatic do_start(input int r, input int sh, input bit rl, input bit pp, input bit with_beat);
    start = 1'b1;
    rows = 13'(r);
    shamt = 5'(sh);
    relu_en = rl;
    pingpang = pp;
    psum_in_valid = with_beat;
    for (int j = 0; j < C; j++) psum_in_skewed[j*PW +: PW] = $urandom;
    start_cyc = cyc;
    cur_rows = r;
    tick;
    start = 1'b0;
    psum_in_valid = 1'b0;
    wq.delete();
    done_cnt = 0;
  endtask

  // Column j of beat b carries element (b-j, j) of the row matrix; anything else is junk.
  task automatic send_beats(input int n, input bit bubbles);
    for (int b = 0; b < n; b++) begin
      if (bubbles && b > 0) begin
        psum_in_valid = 1'b0;
        tick;
      end
      for (int j = 0; j < C; j++) begin
        int r;
        r = b - j;
        psum_in_skewed[j*PW +: PW] = (r >= 0 && r < cur_rows) ? mat[r][j] : $urandom;
      end
      psum_in_valid = 1'b1;
      beat_cyc[b] = cyc;
      tick;
    end
    psum_in_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (done_cnt == 0 && n < bound) begin
      tick;
      n++;
    end
    chk("done_seen", 256'(done_cnt > 0), 256'(1));
    repeat (3) tick;
  endtask

  task automatic check_job(input int r, input int sh, input bit rl, input bit pp);
    chk("wr_count", 256'(wq.size()), 256'(r));
    for (int i = 0; i < r && i < wq.size(); i++) begin
      logic [255:0] ed;
      logic [14:0]  ea;
      ea = {pp, 12'(i), 2'b00};
      for (int j = 0; j < C; j++) ed[j*8 +: 8] = 8'(rq_model(mat[i][j], sh, rl));
      chk($sformatf("row%0d_we", i), 256'(wq[i].we), 256'(4'hf));
      chk($sformatf("row%0d_addr", i), 256'(wq[i].addr), 256'({4{ea}}));
      chk($sformatf("row%0d_data", i), wq[i].data, ed);
      chk($sformatf("row%0d_latency", i), 256'(wq[i].cyc), 256'(beat_cyc[i + C - 1] + 2));
    end
    if (wq.size() > 0) chk("done_cycle", 256'(done_cyc), 256'(wq[wq.size()-1].cyc + 1));
    chk("done_count", 256'(done_cnt), 256'(1));
    chk("busy_at_done", 256'(done_busy), 256'(0));
  endtask

  initial begin
    repeat (3) tick;
    chk("reset_ctrl", 256'({bwe3, bwe2, bwe1, bwe0, bwaddr3, bwaddr2, bwaddr1, bwaddr0,
                            busy, done, overrun}), '0);
    chk("reset_data", {bwdata3, bwdata2, bwdata1, bwdata0}, '0);

    rst = 1'b0;
    psum_in_valid = 1'b1;
    repeat (3) tick;
    psum_in_valid = 1'b0;
    tick;
    chk("prejob_overrun", 256'(overrun), '0);
    chk("prejob_writes", 256'(wq.size()), '0);

    // Row r carries value r in every column.
    fill_mat(4, 1'b0);
    do_start(4, 0, 1'b0, 1'b0, 1'b0);
    chk("busy_after_start", 256'(busy), 256'(1));
    send_beats(35, 1'b0);
    wait_done(20);
    check_job(4, 0, 1'b0, 1'b0);
    if (wq.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("small_row%0d_col31", i), 256'(wq[i].data[255:248]), 256'(i));

    do_start(4, 0, 1'b0, 1'b0, 1'b0);
    send_beats(35, 1'b1);
    wait_done(20);
    check_job(4, 0, 1'b0, 1'b0);

    for (int k = 0; k < 5; k++) begin
      fill_mat(1, 1'b1);
      mat[0][0] = cp[k];
      do_start(1, csh[k], crl[k], 1'b0, 1'b0);
      send_beats(32, 1'b0);
      wait_done(20);
      check_job(1, csh[k], crl[k], 1'b0);
      if (wq.size() > 0) chk($sformatf("corner%0d_col0", k), 256'(wq[0].data[7:0]), 256'(cq[k]));
    end

    fill_mat(2, 1'b1);
    sh_r = $urandom_range(0, 31);
    rl_r = 1'($urandom_range(0, 1));
    do_start(2, sh_r, rl_r, 1'b1, 1'b0);
    send_beats(33, 1'b0);
    wait_done(20);
    check_job(2, sh_r, rl_r, 1'b1);
    if (wq.size() == 2) begin
      chk("pp_addr0", 256'(wq[0].addr[59:45]), 256'(15'h4000));
      chk("pp_addr1", 256'(wq[1].addr[14:0]), 256'(15'h4004));
      chk("pp_bank3_col31", 256'(wq[0].data[255:248]), 256'(8'(rq_model(mat[0][31], sh_r, rl_r))));
    end

    fill_mat(4, 1'b1);
    do_start(4, 3, 1'b0, 1'b0, 1'b0);
    send_beats(36, 1'b0);
    chk("overrun_set", 256'(overrun), 256'(1));
    wait_done(20);
    check_job(4, 3, 1'b0, 1'b0);
    chk("overrun_sticky", 256'(overrun), 256'(1));

    // Abort mid-COLLECT with a beat in the start cycle; the old job's in-flight row must vanish.
    fill_mat(4, 1'b1);
    do_start(4, 2, 1'b1, 1'b0, 1'b0);
    chk("overrun_cleared", 256'(overrun), '0);
    send_beats(33, 1'b0);
    fill_mat(3, 1'b1);
    do_start(3, 1, 1'b0, 1'b0, 1'b1);
    send_beats(34, 1'b0);
    wait_done(20);
    check_job(3, 1, 1'b0, 1'b0);

    fill_mat(4, 1'b1);
    do_start(4, 0, 1'b0, 1'b0, 1'b0);
    send_beats(33, 1'b0);
    rst = 1'b1;
    psum_in_valid = 1'b1;
    tick;
    chk("rst_ctrl", 256'({bwe3, bwe2, bwe1, bwe0, bwaddr3, bwaddr2, bwaddr1, bwaddr0,
                          busy, done, overrun}), '0);
    chk("rst_data", {bwdata3, bwdata2, bwdata1, bwdata0}, '0);
    wq.delete();
    rst = 1'b0;
    repeat (6) tick;
    psum_in_valid = 1'b0;
    tick;
    chk("rst_no_writes", 256'(wq.size()), '0);
    chk("rst_idle_overrun", 256'(overrun), '0);
    chk("rst_busy", 256'(busy), '0);

    do_start(0, 0, 1'b0, 1'b0, 1'b0);
    chk("rows0_busy", 256'(busy), 256'(1));
    wait_done(10);
    chk("rows0_done_cycle", 256'(done_cyc), 256'(start_cyc + 2));
    chk("rows0_writes", 256'(wq.size()), '0);

    fill_mat(4096, 1'b1);
    sh_r = $urandom_range(0, 31);
    rl_r = 1'($urandom_range(0, 1));
    do_start(4096, sh_r, rl_r, 1'b0, 1'b0);
    send_beats(4096 + C - 1, 1'b0);
    wait_done(20);
    check_job(4096, sh_r, rl_r, 1'b0);
    if (wq.size() == 4096) chk("rows4096_last_addr", 256'(wq[4095].addr[14:0]), 256'(15'h3ffc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
